display_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the multi-digit 7-segment display on the gray counter board. Holds a double-buffered set of 4-bit per-digit codes, selects one digit at a time onto the shared `display` decoder input (`cuenta_i`), and drives the active-low digit-enable lines with a programmable dwell time and an inter-digit blanking gap that suppresses ghosting. New display contents are loaded through a request/acknowledge handshake and take effect only at frame boundaries, so a frame never shows mixed old and new values.

---
 rtl/display_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - time-multiplexed 7-segment scan controller with double-buffered digit codes
// Optional leading-zero blanking: define DISPLAY_SCAN_LZ_BLANK_EN.
module display_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    enable_i,
   input  logic                    load_i,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   output logic                    load_ack_o,
   output logic [3:0]              cuenta_o,
   output logic [NUM_DIGITS-1:0]   digit_en_o,
   output logic                    frame_start_o
);

   localparam int DW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [DW-1:0] DWELL_LAST = DW'(PRESCALE - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           index_q, index_d;
   logic [DW-1:0]           dwell_q, dwell_d;
   logic [BW-1:0]           blank_q, blank_d;
   logic [4*NUM_DIGITS-1:0] active_q, active_d;
   logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
   logic                    pending_valid_q, pending_valid_d;
   logic                    load_ack_q, load_ack_d;
   logic                    frame_start_q, frame_start_d;
   logic [3:0]              cuenta_q, cuenta_d;
   logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
   logic                    frame_boundary;
   logic                    lz_off;

   always_comb begin
      state_d         = state_q;
      index_d         = index_q;
      dwell_d         = dwell_q;
      blank_d         = blank_q;
      active_d        = active_q;
      pending_d       = pending_q;
      pending_valid_d = pending_valid_q;
      load_ack_d      = 1'b0;
      frame_start_d   = 1'b0;
      frame_boundary  = 1'b0;

      if (!enable_i) begin
         state_d = IDLE;
         index_d = '0;
         dwell_d = '0;
         blank_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d        = SHOW;
               index_d        = '0;
               dwell_d        = '0;
               frame_boundary = 1'b1;
            end
            SHOW: begin
               if (dwell_q == DWELL_LAST) begin
                  state_d = BLANK;
                  dwell_d = '0;
                  blank_d = '0;
               end else begin
                  dwell_d = dwell_q + 1'b1;
               end
            end
            BLANK: begin
               if (blank_q == BLANK_LAST) begin
                  state_d        = SHOW;
                  blank_d        = '0;
                  dwell_d        = '0;
                  index_d        = (index_q == INDEX_LAST) ? '0 : index_q + 1'b1;
                  frame_boundary = (index_q == INDEX_LAST);
               end else begin
                  blank_d = blank_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (frame_boundary) begin
         frame_start_d = 1'b1;
         if (pending_valid_q) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
         end
      end

      // Checking the post-transfer flag lets a load land in the very cycle pending is emptied.
      if (load_i && !pending_valid_d) begin
         pending_d       = digits_i;
         pending_valid_d = 1'b1;
         load_ack_d      = 1'b1;
      end
   end

`ifdef DISPLAY_SCAN_LZ_BLANK_EN
   always_comb begin
      lz_off = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (k >= int'(index_d) && active_d[4*k +: 4] != 4'h0) lz_off = 1'b0;
      end
      if (index_d == '0) lz_off = 1'b0;
   end
`else
   assign lz_off = 1'b0;
`endif

   always_comb begin
      cuenta_d   = cuenta_q;
      digit_en_d = '1;
      if (state_d == SHOW) begin
         cuenta_d = active_d[4*index_d +: 4];
         if (!lz_off) digit_en_d[index_d] = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         index_q         <= '0;
         dwell_q         <= '0;
         blank_q         <= '0;
         active_q        <= '0;
         pending_q       <= '0;
         pending_valid_q <= 1'b0;
         load_ack_q      <= 1'b0;
         frame_start_q   <= 1'b0;
         cuenta_q        <= 4'h0;
         digit_en_q      <= '1;
      end else begin
         state_q         <= state_d;
         index_q         <= index_d;
         dwell_q         <= dwell_d;
         blank_q         <= blank_d;
         active_q        <= active_d;
         pending_q       <= pending_d;
         pending_valid_q <= pending_valid_d;
         load_ack_q      <= load_ack_d;
         frame_start_q   <= frame_start_d;
         cuenta_q        <= cuenta_d;
         digit_en_q      <= digit_en_d;
      end
   end

   assign load_ack_o    = load_ack_q;
   assign frame_start_o = frame_start_q;
   assign cuenta_o      = cuenta_q;
   assign digit_en_o    = digit_en_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - randomized self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

   localparam int ND    = 4;
   localparam int PS    = 4;
   localparam int BC    = 2;
   localparam int DP    = PS + BC;
   localparam int FRAME = ND * DP;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          load = 1'b0;
   logic [15:0]   digits = '0;
   logic          load_ack_o;
   logic [3:0]    cuenta_o;
   logic [ND-1:0] digit_en_o;
   logic          frame_start_o;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: position within the frame plus the two code buffers
   bit          running = 0;
   int          pos = 0;
   logic [15:0] m_active = '0;
   logic [15:0] m_pending = '0;
   bit          m_pv = 0;
   logic [3:0]  exp_en = 4'hF;
   logic [3:0]  exp_cuenta = 4'h0;
   logic        exp_fs = 1'b0;
   logic        exp_ack = 1'b0;

   display_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PS), .BLANK_CYCLES(BC)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .load_i(load), .digits_i(digits),
      .load_ack_o(load_ack_o), .cuenta_o(cuenta_o), .digit_en_o(digit_en_o),
      .frame_start_o(frame_start_o)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      running = 0; pos = 0; m_active = '0; m_pending = '0; m_pv = 0;
      exp_en = 4'hF; exp_cuenta = 4'h0; exp_fs = 1'b0; exp_ack = 1'b0;
   endtask

   task automatic step();
      int d;
      @(posedge clk);
      exp_fs = 1'b0;
      exp_en = 4'hF;
      if (enable) begin
         pos = running ? (pos + 1) % FRAME : 0;
         running = 1;
         exp_fs = (pos == 0);
         if (pos == 0 && m_pv) begin
            m_active = m_pending;
            m_pv = 0;
         end
         d = pos / DP;
         if ((pos % DP) < PS) begin
            exp_cuenta = m_active[4*d +: 4];
            exp_en = ~(4'b0001 << d);
`ifdef DISPLAY_SCAN_LZ_BLANK_EN
            if (d > 0 && (m_active >> (4*d)) == 16'h0) exp_en = 4'hF;
`endif
         end
      end else begin
         running = 0;
      end
      exp_ack = 1'b0;
      if (load && !m_pv) begin
         m_pending = digits;
         m_pv = 1;
         exp_ack = 1'b1;
      end
      #1;
      if (exp_ack) load = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (digit_en_o !== 4'hF) begin n_fail++; $display("FAIL reset_en got %b exp 1111", digit_en_o); end
      n_tests++; if (cuenta_o !== 4'h0) begin n_fail++; $display("FAIL reset_cuenta got %h exp 0", cuenta_o); end
      n_tests++; if (load_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", load_ack_o); end
      n_tests++; if (frame_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b exp 0", frame_start_o); end
      rst_n = 1'b1;
   endtask

   task automatic test_scan();
      enable = 1'b1;
      step();
      n_tests++; if (digit_en_o !== 4'b1110 || frame_start_o !== 1'b1)
         begin n_fail++; $display("FAIL startup en=%b fs=%b exp 1110/1", digit_en_o, frame_start_o); end
      for (int i = 0; i < 2*FRAME; i++) begin
         step();
         n_tests++; if (digit_en_o !== exp_en) begin n_fail++; $display("FAIL scan_en pos=%0d got %b exp %b", pos, digit_en_o, exp_en); end
         n_tests++; if (frame_start_o !== exp_fs) begin n_fail++; $display("FAIL scan_fs pos=%0d got %b exp %b", pos, frame_start_o, exp_fs); end
      end
   endtask

   task automatic test_load_mid();
      int guard;
      repeat ($urandom_range(3, 15)) step();
      digits = 16'h3210;
      load = 1'b1;
      step();
      n_tests++; if (load_ack_o !== 1'b1) begin n_fail++; $display("FAIL load_ack got %b exp 1", load_ack_o); end
      guard = 0;
      while (!exp_fs && guard < 2*FRAME) begin
         step();
         guard++;
         n_tests++; if (cuenta_o !== exp_cuenta) begin n_fail++; $display("FAIL load_old pos=%0d got %h exp %h", pos, cuenta_o, exp_cuenta); end
      end
      n_tests++; if (!exp_fs) begin n_fail++; $display("FAIL load_timeout got no frame exp frame start"); end
      for (int i = 0; i < FRAME; i++) begin
         n_tests++; if (digit_en_o !== 4'hF && cuenta_o !== 4'(pos / DP))
            begin n_fail++; $display("FAIL load_new pos=%0d got %h exp %0d", pos, cuenta_o, pos / DP); end
         step();
      end
   endtask

   task automatic test_back_to_back();
      int guard;
      repeat ($urandom_range(1, 10)) step();
      digits = 16'h1111;
      load = 1'b1;
      step();
      n_tests++; if (load_ack_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ack1 got %b exp 1", load_ack_o); end
      digits = 16'h2222;
      load = 1'b1;
      guard = 0;
      do begin
         step();
         guard++;
         n_tests++; if (load_ack_o !== exp_ack) begin n_fail++; $display("FAIL b2b_stall pos=%0d got %b exp %b", pos, load_ack_o, exp_ack); end
      end while (!exp_ack && guard < 2*FRAME);
      n_tests++; if (frame_start_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ack2_at_frame got fs=%b exp 1", frame_start_o); end
      for (int i = 0; i < 2*FRAME; i++) begin
         step();
         n_tests++; if (cuenta_o !== exp_cuenta) begin n_fail++; $display("FAIL b2b_cuenta pos=%0d got %h exp %h", pos, cuenta_o, exp_cuenta); end
         n_tests++; if (cuenta_o !== ((i < FRAME - 1) ? 4'h1 : 4'h2)) begin n_fail++; $display("FAIL b2b_order i=%0d got %h", i, cuenta_o); end
      end
   endtask

   task automatic test_enable_drop();
      int guard = 0;
      while (!(pos / DP == 2 && pos % DP == 1) && guard < 2*FRAME) begin step(); guard++; end
      n_tests++; if (digit_en_o !== 4'b1011) begin n_fail++; $display("FAIL drop_pre got %b exp 1011", digit_en_o); end
      enable = 1'b0;
      step();
      n_tests++; if (digit_en_o !== 4'hF) begin n_fail++; $display("FAIL drop_off got %b exp 1111", digit_en_o); end
      repeat (3) step();
      enable = 1'b1;
      step();
      n_tests++; if (digit_en_o !== 4'b1110 || frame_start_o !== 1'b1)
         begin n_fail++; $display("FAIL drop_restart en=%b fs=%b exp 1110/1", digit_en_o, frame_start_o); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         if (!load && $urandom_range(0, 19) == 0) begin
            digits = 16'($urandom);
            load = 1'b1;
         end
         step();
         n_tests++; if (digit_en_o !== exp_en) begin n_fail++; $display("FAIL rnd_en i=%0d got %b exp %b", i, digit_en_o, exp_en); end
         n_tests++; if (cuenta_o !== exp_cuenta) begin n_fail++; $display("FAIL rnd_cuenta i=%0d got %h exp %h", i, cuenta_o, exp_cuenta); end
         n_tests++; if (load_ack_o !== exp_ack) begin n_fail++; $display("FAIL rnd_ack i=%0d got %b exp %b", i, load_ack_o, exp_ack); end
         n_tests++; if (frame_start_o !== exp_fs) begin n_fail++; $display("FAIL rnd_fs i=%0d got %b exp %b", i, frame_start_o, exp_fs); end
      end
      load = 1'b0;
      step();
   endtask

   task automatic test_async_reset();
      enable = 1'b1;
      step();
      step();
      digits = 16'h9876;
      load = 1'b1;
      step();
      while (!(pos % DP == 1 && pos / DP < ND && !m_pv)) step();
      digits = 16'hABCD;
      load = 1'b1;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++; if (digit_en_o !== 4'hF || cuenta_o !== 4'h0 || load_ack_o !== 1'b0 || frame_start_o !== 1'b0)
         begin n_fail++; $display("FAIL async_reset en=%b cuenta=%h ack=%b fs=%b exp 1111/0/0/0", digit_en_o, cuenta_o, load_ack_o, frame_start_o); end
      model_reset();
      enable = 1'b0;
      load = 1'b0;
      step();
      rst_n = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < FRAME + 1; i++) begin
         step();
         n_tests++; if (cuenta_o !== 4'h0) begin n_fail++; $display("FAIL reset_discard i=%0d got %h exp 0", i, cuenta_o); end
         n_tests++; if (digit_en_o !== exp_en) begin n_fail++; $display("FAIL reset_scan i=%0d got %b exp %b", i, digit_en_o, exp_en); end
      end
   endtask

`ifdef DISPLAY_SCAN_LZ_BLANK_EN
   task automatic test_lz();
      int guard = 0;
      digits = 16'h0050;
      load = 1'b1;
      step();
      while (!(exp_fs && m_active == 16'h0050) && guard < 3*FRAME) begin step(); guard++; end
      for (int i = 0; i < FRAME; i++) begin
         n_tests++; if (digit_en_o !== exp_en) begin n_fail++; $display("FAIL lz_en pos=%0d got %b exp %b", pos, digit_en_o, exp_en); end
         n_tests++; if (pos / DP >= 2 && digit_en_o !== 4'hF) begin n_fail++; $display("FAIL lz_off pos=%0d got %b exp 1111", pos, digit_en_o); end
         step();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_scan();
      test_load_mid();
      test_back_to_back();
      test_enable_drop();
      test_random();
      test_async_reset();
`ifdef DISPLAY_SCAN_LZ_BLANK_EN
      test_lz();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
